// File: rtl/xpb_lut_accum.sv
// ============================================================================
// xpb_lut_accum : banked lookup table, one entry summed per segment per cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module xpb_lut_accum #(
  parameter  int DATA_W = 1024,
  parameter  int IDX_W  = 5,
  parameter  int NSEG   = 4,
  localparam int CNT_W  = $clog2(NSEG) + 1,
  localparam int SUM_W  = DATA_W + CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [CNT_W-1:0]       wr_seg,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NSEG*IDX_W-1:0]  in_idx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SUM_W-1:0]       out_data
);

  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_W-1:0]       r_table [NSEG][DEPTH];
  logic [NSEG*IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]        r_seg_cnt;
  logic [SUM_W-1:0]        r_acc;
  logic [IDX_W-1:0]        w_rd_idx;
  logic [DATA_W-1:0]       w_rd_data;
  logic                    w_last;

  // Table storage is deliberately not reset; entry 0 of each bank is never written.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_idx != '0)) begin
      for (int s = 0; s < NSEG; s++) begin
        if (wr_seg == CNT_W'(s)) begin
          r_table[s][wr_idx] <= wr_data;
        end
      end
    end
  end

  // Read port sees the pre-edge table, so a same-edge write sums the old value.
  always_comb begin
    w_rd_idx  = '0;
    w_rd_data = '0;
    for (int s = 0; s < NSEG; s++) begin
      if (r_seg_cnt == CNT_W'(s)) begin
        w_rd_idx  = r_idx[s*IDX_W +: IDX_W];
        w_rd_data = r_table[s][w_rd_idx];
      end
    end
    if (w_rd_idx == '0) begin
      w_rd_data = '0;
    end
  end

  assign w_last = (r_seg_cnt == CNT_W'(NSEG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = ACC;
      ACC:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_seg_cnt <= '0;
      r_acc     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_idx     <= in_idx;
            r_seg_cnt <= '0;
            r_acc     <= '0;
          end
        end
        ACC: begin
          r_acc     <= r_acc + {{CNT_W{1'b0}}, w_rd_data};
          r_seg_cnt <= r_seg_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_data  = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_xpb_lut_accum.sv
// ============================================================================
// tb_xpb_lut_accum : scoreboard bench for xpb_lut_accum at default parameters
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_xpb_lut_accum;

  localparam int DATA_W = 1024;
  localparam int IDX_W  = 5;
  localparam int NSEG   = 4;
  localparam int CNT_W  = 3;
  localparam int SUM_W  = DATA_W + CNT_W;
  localparam int IW     = NSEG * IDX_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [CNT_W-1:0]  wr_seg;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              in_valid;
  logic              in_ready;
  logic [IW-1:0]     in_idx;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [SUM_W-1:0] sb[$];

  xpb_lut_accum #(.DATA_W(DATA_W), .IDX_W(IDX_W), .NSEG(NSEG)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_seg(wr_seg), .wr_idx(wr_idx), .wr_data(wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] pk(input int a, input int b, input int c, input int d);
    return {IDX_W'(d), IDX_W'(c), IDX_W'(b), IDX_W'(a)};
  endfunction

  task automatic do_write(input int seg, input int idx, input logic [DATA_W-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_seg = CNT_W'(seg); wr_idx = IDX_W'(idx); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Drives one accept edge and scrambles in_idx afterwards; returns at the negedge after accept.
  task automatic issue(input logic [IW-1:0] idx, input logic [SUM_W-1:0] exp);
    @(negedge clk);
    in_idx = idx; in_valid = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    in_idx   = IW'($urandom);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pop_exp(output logic [SUM_W-1:0] e);
    if (sb.size() != 0) e = sb.pop_front();
    else e = '1;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++;
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %0h want 0", out_data[63:0]); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc;
    logic [SUM_W-1:0] e;
    for (int s = 0; s < NSEG; s++) do_write(s, 1, DATA_W'(s + 1));
    issue(pk(1, 1, 1, 1), SUM_W'(10));
    wait_valid(cyc);
    pop_exp(e);
    n_tests++;
    if (cyc !== NSEG) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", cyc, NSEG); end
    n_tests++;
    if (out_data !== e) begin n_fail++; $display("FAIL basic_data got %0h want %0h", out_data[63:0], e[63:0]); end
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready_done got %b want 0", in_ready); end
    consume();
  endtask

  task automatic test_zero_idx();
    int cyc;
    logic [SUM_W-1:0] e;
    logic [IW-1:0] pats [3];
    logic [SUM_W-1:0] exps [3];
    do_write(0, 0, DATA_W'(8'hFF));
    do_write(2, 3, DATA_W'(7));
    do_write(0, 3, DATA_W'(11));
    do_write(4, 3, DATA_W'(99));
    do_write(7, 3, DATA_W'(55));
    pats[0] = pk(0, 0, 0, 0); exps[0] = SUM_W'(0);
    pats[1] = pk(0, 0, 3, 0); exps[1] = SUM_W'(7);
    pats[2] = pk(3, 0, 3, 0); exps[2] = SUM_W'(18);
    for (int i = 0; i < 3; i++) begin
      issue(pats[i], exps[i]);
      wait_valid(cyc);
      pop_exp(e);
      n_tests++;
      if (cyc !== NSEG) begin n_fail++; $display("FAIL zero_idx_latency[%0d] got %0d want %0d", i, cyc, NSEG); end
      n_tests++;
      if (out_data !== e) begin n_fail++; $display("FAIL zero_idx_data[%0d] got %0h want %0h", i, out_data[63:0], e[63:0]); end
      consume();
    end
  endtask

  task automatic test_carry();
    int cyc;
    logic [SUM_W-1:0] e;
    logic [SUM_W-1:0] sum;
    logic [DATA_W-1:0] ones;
    ones = '1;
    sum  = '0;
    for (int s = 0; s < NSEG; s++) begin
      do_write(s, 31, ones);
      sum = sum + {{CNT_W{1'b0}}, ones};
    end
    issue(pk(31, 31, 31, 31), sum);
    wait_valid(cyc);
    pop_exp(e);
    n_tests++;
    if (cyc !== NSEG) begin n_fail++; $display("FAIL carry_latency got %0d want %0d", cyc, NSEG); end
    n_tests++;
    if (out_data !== e)
      begin n_fail++; $display("FAIL carry_data got hi=%h lo=%h want hi=%h lo=%h",
        out_data[SUM_W-1:SUM_W-64], out_data[63:0], e[SUM_W-1:SUM_W-64], e[63:0]); end
    n_tests++;
    if (out_data[1025] !== 1'b1) begin n_fail++; $display("FAIL carry_bit1025 got %b want 1", out_data[1025]); end
    consume();
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [SUM_W-1:0] e;
    issue(pk(1, 1, 1, 1), SUM_W'(10));
    wait_valid(cyc);
    pop_exp(e);
    n_tests++;
    if (cyc !== NSEG) begin n_fail++; $display("FAIL bp_latency got %0d want %0d", cyc, NSEG); end
    in_idx = pk(1, 0, 3, 1);
    in_valid = 1'b1;
    sb.push_back(SUM_W'(1 + 7 + 4));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got valid=%b data=%0h ready=%b want valid=1 data=%0h ready=0",
                 i, out_valid, out_data[63:0], in_ready, e[63:0]);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_exit got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_reaccept got ready=%b want 0", in_ready); end
    wait_valid(cyc);
    pop_exp(e);
    n_tests++;
    if (cyc !== NSEG) begin n_fail++; $display("FAIL bp_second_latency got %0d want %0d", cyc, NSEG); end
    n_tests++;
    if (out_data !== e) begin n_fail++; $display("FAIL bp_second_data got %0h want %0h", out_data[63:0], e[63:0]); end
    consume();
  endtask

  task automatic test_collision();
    int cyc;
    logic [SUM_W-1:0] e;
    do_write(1, 5, DATA_W'(5));
    issue(pk(0, 5, 0, 0), SUM_W'(5));
    // next posedge is the ACC edge with seg_cnt==1
    @(negedge clk);
    wr_en = 1'b1; wr_seg = CNT_W'(1); wr_idx = IDX_W'(5); wr_data = DATA_W'(9);
    @(negedge clk);
    wr_en = 1'b0;
    wait_valid(cyc);
    pop_exp(e);
    n_tests++;
    if (cyc !== NSEG - 2) begin n_fail++; $display("FAIL coll_latency got %0d want %0d", cyc, NSEG - 2); end
    n_tests++;
    if (out_data !== e) begin n_fail++; $display("FAIL coll_old_value got %0d want %0d", out_data[63:0], e[63:0]); end
    consume();
    issue(pk(0, 5, 0, 0), SUM_W'(9));
    wait_valid(cyc);
    pop_exp(e);
    n_tests++;
    if (out_data !== e) begin n_fail++; $display("FAIL coll_new_value got %0d want %0d", out_data[63:0], e[63:0]); end
    consume();
  endtask

  task automatic test_mid_reset();
    int cyc;
    logic [SUM_W-1:0] e;
    issue(pk(1, 1, 1, 1), SUM_W'(10));
    void'(sb.pop_back());
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async got valid=%b ready=%b data=%0h want 0 1 0", out_valid, in_ready, out_data[63:0]);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL mid_reset_hold[%0d] got valid=%b ready=%b want 0 1", i, out_valid, in_ready);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_idx = pk(1, 1, 1, 1); in_valid = 1'b1;
    sb.push_back(SUM_W'(10));
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(cyc);
    pop_exp(e);
    n_tests++;
    if (cyc !== NSEG) begin n_fail++; $display("FAIL mid_reset_latency got %0d want %0d", cyc, NSEG); end
    n_tests++;
    if (out_data !== e) begin n_fail++; $display("FAIL mid_reset_retained got %0d want %0d", out_data[63:0], e[63:0]); end
    consume();
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_seg = '0; wr_idx = '0; wr_data = '0;
    in_valid = 1'b0; in_idx = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero_idx();
    test_carry();
    test_backpressure();
    test_collision();
    test_mid_reset();
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
